// File: rtl/pipe_flush_ctrl_pkg.sv
// Shared definitions for the pipeline flush controller.
//   state_e            controller state (RUN / REDIR / HALT)
//   EX_VECTOR_DEFAULT  exception entry PC
//   NSTAGE_DEFAULT     number of flushed stages
//   STG_*              bit index of each stage inside the flush vector
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [31:0] EX_VECTOR_DEFAULT = 32'hBFC0_0380;
  localparam int          NSTAGE_DEFAULT    = 4;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;

endpackage

// File: rtl/pipe_flush_ctrl_if.sv
// Bundle between the WB stage / fetch and the flush controller.
//   master : the controller (consumes WB events and fetch accept,
//            drives flush, redirect, stall, halt and debug counter)
//   slave  : the surrounding pipeline
interface pipe_flush_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEFAULT,
  parameter int CNT_W  = 16
);
  logic              ex;
  logic              eret;
  logic              hlt;
  logic [31:0]       epc_in;
  logic              if_allowin;
  logic [NSTAGE-1:0] flush;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              stall_if;
  logic              halted;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    input  ex, eret, hlt, epc_in, if_allowin,
    output flush, redirect_valid, redirect_pc, stall_if, halted, flush_cnt
  );

  modport slave (
    output ex, eret, hlt, epc_in, if_allowin,
    input  flush, redirect_valid, redirect_pc, stall_if, halted, flush_cnt
  );
endinterface

// File: rtl/pipe_flush_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock and synchronous active-high reset
//   en       : increment request (ignored once the counter is full)
//   clr      : synchronous clear
//   q        : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign q = count_reg;
endmodule

// File: rtl/pipe_flush_ctrl.sv
// Pipeline recovery sequencer beside the WB stage.
// Turns exception / ERET / halt reports into a one-cycle flush of all
// stages plus a PC redirect that is held until fetch accepts it. A halt
// is permanent until reset. Accepted ex/eret events are counted.
//   clk, rst : clock and synchronous active-high reset
//   bus      : pipe_flush_ctrl_if master side (WB events, fetch accept,
//              flush / redirect / stall / halted / flush_cnt outputs)
module pipe_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EX_VECTOR = EX_VECTOR_DEFAULT,
  parameter int          NSTAGE    = NSTAGE_DEFAULT,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_flush_ctrl_if.master bus
);
  state_e            state_reg, state_next;
  logic [31:0]       pc_reg, pc_next;
  logic [NSTAGE-1:0] flush_reg, flush_next;
  logic              cnt_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      pc_reg    <= '0;
      flush_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      flush_reg <= flush_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    flush_next = '0;
    cnt_en     = 1'b0;
    if (bus.hlt) begin
      // Halt wins over everything; only the entry cycle flushes.
      state_next = HALT;
      if (state_reg != HALT) flush_next = '1;
    end else begin
      case (state_reg)
        RUN: begin
          if (bus.ex) begin
            state_next = REDIR;
            pc_next    = EX_VECTOR;
            flush_next = '1;
            cnt_en     = 1'b1;
          end else if (bus.eret) begin
            state_next = REDIR;
            pc_next    = bus.epc_in;
            flush_next = '1;
            cnt_en     = 1'b1;
          end
        end
        REDIR: begin
          // A fresh exception retargets and restarts the handshake, so an
          // accept in the same cycle refers to the stale target and is dropped.
          if (bus.ex) begin
            pc_next    = EX_VECTOR;
            flush_next = '1;
            cnt_en     = 1'b1;
          end else if (bus.if_allowin) begin
            state_next = RUN;
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (1'b0),
    .q   (bus.flush_cnt)
  );

  // Redirect, stall and halt follow directly from the registered state.
  assign bus.flush          = flush_reg;
  assign bus.redirect_valid = (state_reg == REDIR);
  assign bus.redirect_pc    = pc_reg;
  assign bus.stall_if       = (state_reg != RUN);
  assign bus.halted         = (state_reg == HALT);
endmodule

// File: tb/tb_pipe_flush_ctrl.sv
module tb_pipe_flush_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam logic [31:0] EPC = 32'h8000_1234;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_flush_ctrl_if #(.NSTAGE(4), .CNT_W(16)) bus ();
  pipe_flush_ctrl_if #(.NSTAGE(4), .CNT_W(3))  sbus ();

  pipe_flush_ctrl #(.EX_VECTOR(VEC), .NSTAGE(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Narrow-counter instance used to reach saturation in a few cycles.
  pipe_flush_ctrl #(.EX_VECTOR(VEC), .NSTAGE(4), .CNT_W(3)) sdut (
    .clk (clk),
    .rst (rst),
    .bus (sbus.master)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] f, input bit rv,
                         input logic [31:0] pc, input bit st, input bit hl,
                         input logic [15:0] c);
    chk({tag, ".flush"},          32'(bus.flush),          32'(f));
    chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(rv));
    chk({tag, ".redirect_pc"},    bus.redirect_pc,         pc);
    chk({tag, ".stall_if"},       32'(bus.stall_if),       32'(st));
    chk({tag, ".halted"},         32'(bus.halted),         32'(hl));
    chk({tag, ".flush_cnt"},      32'(bus.flush_cnt),      32'(c));
  endtask

  // Apply one cycle of inputs; return sampled 1 time unit after the edge.
  task automatic drive(input bit r, input bit e, input bit er, input bit h,
                       input bit a, input logic [31:0] epc);
    rst            = r;
    bus.ex         = e;
    bus.eret       = er;
    bus.hlt        = h;
    bus.if_allowin = a;
    bus.epc_in     = epc;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: "is a redirect outstanding", "is the core halted",
  // the current target and a saturating event tally.
  bit          m_halt, m_pend;
  logic [31:0] m_pc;
  int          m_cnt;
  logic [3:0]  m_flush;

  task automatic model_step(input bit r, input bit e, input bit er, input bit h,
                            input bit a, input logic [31:0] epc);
    bit event_taken;
    event_taken = 1'b0;
    m_flush     = 4'h0;
    if (r) begin
      m_halt = 0; m_pend = 0; m_pc = 0; m_cnt = 0;
    end else if (m_halt) begin
      // frozen until reset
    end else if (h) begin
      m_halt = 1; m_pend = 0; m_flush = 4'hF;
    end else if (e) begin
      m_pc = VEC; event_taken = 1'b1;
    end else if (er && !m_pend) begin
      m_pc = epc; event_taken = 1'b1;
    end else if (m_pend && a) begin
      m_pend = 0;
    end
    if (event_taken) begin
      m_pend  = 1;
      m_flush = 4'hF;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  typedef struct {
    bit          ex, eret, hlt, alw;
    logic [31:0] epc;
    logic [3:0]  flush;
    bit          rv;
    logic [31:0] pc;
    bit          stall, halted;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input bit e, input bit er, input bit h, input bit a,
                              input logic [31:0] epc, input logic [3:0] f, input bit rv,
                              input logic [31:0] pc, input bit st, input bit hl,
                              input logic [15:0] c);
    vec_t v;
    v.ex = e; v.eret = er; v.hlt = h; v.alw = a; v.epc = epc;
    v.flush = f; v.rv = rv; v.pc = pc; v.stall = st; v.halted = hl; v.cnt = c;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    bit          r, e, er, h, a;
    logic [31:0] epc;

    //            ex er h  al epc            flush rv pc   st hl cnt
    tbl[0]  = mk(1, 0, 0, 1, 32'h0,         4'hF, 1, VEC, 1, 0, 1);  // ex, accepted at once
    tbl[1]  = mk(0, 0, 0, 1, 32'h0,         4'h0, 0, VEC, 0, 0, 1);
    tbl[2]  = mk(0, 1, 0, 0, EPC,           4'hF, 1, EPC, 1, 0, 2);  // eret, fetch busy
    tbl[3]  = mk(0, 0, 0, 0, 32'h0,         4'h0, 1, EPC, 1, 0, 2);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,         4'h0, 1, EPC, 1, 0, 2);
    tbl[5]  = mk(0, 0, 0, 0, 32'h0,         4'h0, 1, EPC, 1, 0, 2);
    tbl[6]  = mk(0, 0, 0, 1, 32'h0,         4'h0, 0, EPC, 0, 0, 2);
    tbl[7]  = mk(1, 1, 0, 0, EPC,           4'hF, 1, VEC, 1, 0, 3);  // ex beats eret
    tbl[8]  = mk(0, 1, 0, 0, 32'h1111_0000, 4'h0, 1, VEC, 1, 0, 3);  // eret ignored in REDIR
    tbl[9]  = mk(1, 0, 0, 1, 32'h0,         4'hF, 1, VEC, 1, 0, 4);  // ex in REDIR, accept dropped
    tbl[10] = mk(0, 0, 0, 1, 32'h0,         4'h0, 0, VEC, 0, 0, 4);
    tbl[11] = mk(0, 1, 0, 0, EPC,           4'hF, 1, EPC, 1, 0, 5);
    tbl[12] = mk(0, 0, 1, 0, 32'h0,         4'hF, 0, EPC, 1, 1, 5);  // hlt during REDIR
    tbl[13] = mk(1, 0, 0, 1, 32'h0,         4'h0, 0, EPC, 1, 1, 5);  // ex ignored when halted
    tbl[14] = mk(0, 1, 0, 1, 32'h2222_0000, 4'h0, 0, EPC, 1, 1, 5);
    tbl[15] = mk(0, 0, 1, 0, 32'h0,         4'h0, 0, EPC, 1, 1, 5);  // no re-flush on repeated hlt

    sbus.ex = 0; sbus.eret = 0; sbus.hlt = 0; sbus.if_allowin = 1; sbus.epc_in = 0;

    // Reset held for two cycles.
    drive(1, 0, 0, 0, 0, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0);
    chk_all("reset", 4'h0, 0, 32'h0, 0, 0, 16'h0);
    $display("reset: flush=%h rv=%0d pc=%h cnt=%0d", bus.flush, bus.redirect_valid, bus.redirect_pc, bus.flush_cnt);

    // Saturation on the 3-bit counter instance: ex held high counts every cycle.
    sbus.ex = 1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat_cnt[%0d]", k), 32'(sbus.flush_cnt), (k < 7) ? k : 7);
      $display("sat: cycle %0d flush_cnt=%0d", k, sbus.flush_cnt);
    end
    sbus.ex = 0;
    chk("main_cnt_untouched", 32'(bus.flush_cnt), 32'h0);

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      drive(0, tbl[i].ex, tbl[i].eret, tbl[i].hlt, tbl[i].alw, tbl[i].epc);
      chk_all($sformatf("vec%0d", i), tbl[i].flush, tbl[i].rv, tbl[i].pc,
              tbl[i].stall, tbl[i].halted, tbl[i].cnt);
      $display("vec%0d: ex=%0d eret=%0d hlt=%0d alw=%0d -> flush=%h rv=%0d pc=%h stall=%0d halted=%0d cnt=%0d",
               i, tbl[i].ex, tbl[i].eret, tbl[i].hlt, tbl[i].alw, bus.flush,
               bus.redirect_valid, bus.redirect_pc, bus.stall_if, bus.halted, bus.flush_cnt);
    end

    // Reset out of HALT.
    drive(1, 0, 0, 0, 0, 32'h0);
    chk_all("rst_from_halt", 4'h0, 0, 32'h0, 0, 0, 16'h0);
    $display("rst from halt: halted=%0d stall=%0d", bus.halted, bus.stall_if);
    // Reset mid-redirect, with a coincident ex.
    drive(0, 1, 0, 0, 0, 32'h0);
    chk_all("ex_before_rst", 4'hF, 1, VEC, 1, 0, 16'h1);
    drive(1, 1, 0, 0, 0, 32'h0);
    chk_all("rst_mid_redir", 4'h0, 0, 32'h0, 0, 0, 16'h0);
    $display("rst mid redirect: rv=%0d pc=%h cnt=%0d", bus.redirect_valid, bus.redirect_pc, bus.flush_cnt);
    // hlt and ex together from RUN: halt wins, not counted.
    drive(0, 1, 1, 1, 1, EPC);
    chk_all("hlt_beats_ex", 4'hF, 0, 32'h0, 1, 1, 16'h0);
    $display("hlt+ex: flush=%h halted=%0d cnt=%0d", bus.flush, bus.halted, bus.flush_cnt);

    // Randomized run against the reference model.
    drive(1, 0, 0, 0, 0, 32'h0);
    model_step(1, 0, 0, 0, 0, 32'h0);
    for (int n = 0; n < 600; n++) begin
      r   = m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 5) == 0);
      er  = ($urandom_range(0, 4) == 0);
      h   = ($urandom_range(0, 49) == 0);
      a   = ($urandom_range(0, 2) != 0);
      epc = $urandom;
      drive(r, e, er, h, a, epc);
      model_step(r, e, er, h, a, epc);
      chk_all($sformatf("rnd%0d", n), m_flush, m_pend, m_pc, m_pend || m_halt,
              m_halt, 16'(m_cnt));
      $display("rnd%0d: rst=%0d ex=%0d eret=%0d hlt=%0d alw=%0d -> flush=%h rv=%0d pc=%h cnt=%0d",
               n, r, e, er, h, a, bus.flush, bus.redirect_valid, bus.redirect_pc, bus.flush_cnt);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
